// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter that shares the 4-input, 8-bit asynchronous mux between
//   four requesters. It drives the mux select directly and hands each requester
//   a one-hot grant. With MAX_HOLD != 0, an owner is rotated out after MAX_HOLD
//   consecutive cycles whenever someone else is waiting, so no source starves.
//
// Ports
//   clk      in   1       system clock, rising edge
//   rst      in   1       asynchronous, active-high reset
//   req      in   4       per-source request
//   grant    out  4       registered one-hot grant, zero when no owner
//   select   out  2       registered mux select, index of current/last owner
//   busy     out  1       OR of grant
//   hold_cnt out  HOLD_W  cycles the current owner has held the grant, minus 1
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    output logic [3:0]        grant,
    output logic [1:0]        select,
    output logic              busy,
    output logic [HOLD_W-1:0] hold_cnt
);

    typedef enum logic {IDLE, OWNED} state_t;

    // Saturation point of the hold counter: MAX_HOLD-1 when the hold limit is
    // enabled, otherwise all-ones.
    localparam logic [HOLD_W-1:0] HOLD_LIM =
        (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic [3:0]        grant_q, grant_d;
    logic [1:0]        select_q, select_d;
    logic [1:0]        last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    // Returns {found, index} of the first set bit of mask, scanning from
    // start upward and wrapping. The loop runs backwards so that the earliest
    // position in the scan order is the last one written and therefore wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask,
                                           input logic [1:0] start);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (mask[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    logic [2:0] pick_idle, pick_rel, pick_exp;
    logic [3:0] own_oh;
    logic [3:0] others;

    assign own_oh    = 4'b0001 << select_q;
    assign others    = req & ~own_oh;
    assign pick_idle = rr_pick(req, last_q + 2'd1);
    // On release req[owner] is already clear, so scanning all four from
    // owner+1 naturally leaves the owner for last.
    assign pick_rel  = rr_pick(req, select_q + 2'd1);
    assign pick_exp  = rr_pick(others, select_q + 2'd1);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        select_d = select_q;
        last_d   = last_q;
        hold_d   = hold_q;
        unique case (state_q)
            IDLE: begin
                if (pick_idle[2]) begin
                    grant_d  = 4'b0001 << pick_idle[1:0];
                    select_d = pick_idle[1:0];
                    last_d   = pick_idle[1:0];
                    hold_d   = '0;
                    state_d  = OWNED;
                end
            end
            OWNED: begin
                if (!req[select_q]) begin
                    if (pick_rel[2]) begin
                        // Direct hand-over, no idle cycle between owners.
                        grant_d  = 4'b0001 << pick_rel[1:0];
                        select_d = pick_rel[1:0];
                        last_d   = pick_rel[1:0];
                        hold_d   = '0;
                    end else begin
                        // select is left alone so the mux output stays stable.
                        grant_d = 4'b0000;
                        hold_d  = '0;
                        state_d = IDLE;
                    end
                end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LIM) && pick_exp[2]) begin
                    grant_d  = 4'b0001 << pick_exp[1:0];
                    select_d = pick_exp[1:0];
                    last_d   = pick_exp[1:0];
                    hold_d   = '0;
                end else if (hold_q != HOLD_LIM) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= 4'b0000;
            select_q <= 2'd0;
            last_q   <= 2'd3;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
        end
    end

    assign grant    = grant_q;
    assign select   = select_q;
    assign busy     = |grant_q;
    assign hold_cnt = hold_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int HOLD_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req;
    logic [3:0]        grant;
    logic [1:0]        select;
    logic              busy;
    logic [HOLD_W-1:0] hold_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .select   (select),
        .busy     (busy),
        .hold_cnt (hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_rst();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_g;
        // Test 1: reset without a clock edge, then idle with req=0.
        rst = 1'b1;
        req = 4'b0000;
        #2;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_select", 32'(select), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_hold", 32'(hold_cnt), 32'h0);
        step();
        rst = 1'b0;
        repeat (5) step();
        check("idle_grant", 32'(grant), 32'h0);
        check("idle_select", 32'(select), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);

        // Test 2: single requester 2, held 6 clocks then dropped.
        req = 4'b0100;
        step();
        check("t2_grant", 32'(grant), 32'h4);
        check("t2_select", 32'(select), 32'h2);
        check("t2_hold0", 32'(hold_cnt), 32'h0);
        for (int k = 1; k < 6; k++) begin
            step();
            check("t2_grant_held", 32'(grant), 32'h4);
        end
        req = 4'b0000;
        step();
        check("t2_rel_grant", 32'(grant), 32'h0);
        check("t2_rel_busy", 32'(busy), 32'h0);
        check("t2_rel_select", 32'(select), 32'h2);

        // Test 3: all four requesting, rotation every MAX_HOLD cycles.
        pulse_rst();
        req = 4'b1111;
        for (int o = 0; o < 5; o++) begin
            exp_g = 4'b0001 << (o % 4);
            for (int h = 0; h < 4; h++) begin
                step();
                check("t3_grant", 32'(grant), 32'(exp_g));
                check("t3_select", 32'(select), 32'(o % 4));
                check("t3_hold", 32'(hold_cnt), 32'(h));
            end
        end

        // Test 4: owner 1 releases at hold_cnt=1, direct hand-over to 3.
        pulse_rst();
        req = 4'b1010;
        step();
        check("t4_grant", 32'(grant), 32'h2);
        check("t4_busy0", 32'(busy), 32'h1);
        step();
        check("t4_hold1", 32'(hold_cnt), 32'h1);
        check("t4_busy1", 32'(busy), 32'h1);
        req = 4'b1000;
        step();
        check("t4_ho_grant", 32'(grant), 32'h8);
        check("t4_ho_select", 32'(select), 32'h3);
        check("t4_ho_hold", 32'(hold_cnt), 32'h0);
        check("t4_ho_busy", 32'(busy), 32'h1);

        // Test 5: lone requester saturates hold_cnt, then rotates on contention.
        pulse_rst();
        req = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            step();
            check("t5_grant", 32'(grant), 32'h1);
            check("t5_hold", 32'(hold_cnt), 32'((k < 3) ? k : 3));
        end
        req = 4'b0101;
        step();
        check("t5_rot_grant", 32'(grant), 32'h4);
        check("t5_rot_select", 32'(select), 32'h2);
        check("t5_rot_hold", 32'(hold_cnt), 32'h0);

        // Test 6: async reset while source 2 owns the mux.
        pulse_rst();
        req = 4'b0100;
        step();
        check("t6_own2", 32'(grant), 32'h4);
        req = 4'b0110;
        step();
        check("t6_still2", 32'(grant), 32'h4);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_grant", 32'(grant), 32'h0);
        check("t6_rst_select", 32'(select), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        step();
        check("t6_regrant", 32'(grant), 32'h2);
        check("t6_reselect", 32'(select), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
